rate_gen_multi: RTL

Parametrised clock-enable and rate generator on CLK_NX. It produces the VGA pixel-rate square wave and a one-cycle pixel strobe. It also produces NCH independent blink channels, each with a divisor that can be reprogrammed at runtime. The block feeds the display timing logic and every blinking or cursor element. Divisor updates use a valid/ready handshake and take effect only at half-period boundaries, so blink waveforms never glitch.

---
 rtl/rate_gen_multi_if.sv | 14 +
 rtl/rate_gen_multi.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rate_gen_multi_if.sv
// Divisor configuration handshake into rate_gen_multi.
// The writer uses the master modport; the rate generator uses the slave modport.
interface rate_gen_multi_if #(
    parameter int CH_W  = 3,
    parameter int DIV_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_half;

    modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/rate_gen_multi.sv
// Pixel-rate square wave/strobe plus NCH runtime-reprogrammable blink channels.
// New divisors are taken only at a channel's wrap, so waveforms never glitch.
module rate_gen_multi #(
    parameter int PIX_DIV  = 4,
    parameter int NCH      = 2,
    parameter int DIV_W    = 24,
    parameter int DEF_HALF = 12499999,
    parameter int CH_W     = 3
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sclr,
    rate_gen_multi_if.slave  cfg,
    output logic             o_pixel_rate,
    output logic             o_pixel_tick,
    output logic [NCH-1:0]   o_blink,
    output logic [NCH-1:0]   o_blink_tick
);
    localparam int               PCW      = (PIX_DIV > 2) ? $clog2(PIX_DIV / 2) : 1;
    localparam logic [PCW-1:0]   PIX_TC   = PCW'(PIX_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEF_HALF);

    logic [PCW-1:0] r_pix_cnt;
    logic           r_pixel_rate;
    logic           r_pixel_tick;
    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_blink;
    logic [NCH-1:0] w_blink_tick;
    logic           w_sel_pend;
    logic           w_cfg_ready;
    logic           w_accept;

    always_ff @(posedge CLK_NX or posedge reset) begin
        if (reset) begin
            r_pix_cnt    <= '0;
            r_pixel_rate <= 1'b0;
            r_pixel_tick <= 1'b0;
        end else if (i_sclr) begin
            r_pix_cnt    <= '0;
            r_pixel_rate <= 1'b0;
            r_pixel_tick <= 1'b0;
        end else if (i_en) begin
            if (r_pix_cnt == PIX_TC) begin
                r_pix_cnt    <= '0;
                r_pixel_rate <= ~r_pixel_rate;
                r_pixel_tick <= ~r_pixel_rate;
            end else begin
                r_pix_cnt    <= r_pix_cnt + 1'b1;
                r_pixel_tick <= 1'b0;
            end
        end else begin
            r_pixel_tick <= 1'b0;
        end
    end

    // Out-of-range channels never match, so they always see a ready slot.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                w_sel_pend = w_pend[i];
            end
        end
    end

    assign w_cfg_ready   = ~reset & ~w_sel_pend;
    assign cfg.cfg_ready = w_cfg_ready;
    assign w_accept      = cfg.cfg_valid & w_cfg_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_half;
        logic [DIV_W-1:0] r_pend_val;
        logic             r_pend;
        logic             r_blink;
        logic             r_tick;
        logic             w_term;
        logic             w_wr;

        assign w_term = i_en & ~i_sclr & (r_cnt == r_half);
        assign w_wr   = w_accept & (cfg.cfg_ch == CH_W'(g));

        // A write can only land while nothing is pending, so it never races the apply.
        always_ff @(posedge CLK_NX or posedge reset) begin
            if (reset) begin
                r_cnt      <= '0;
                r_half     <= HALF_RST;
                r_pend_val <= '0;
                r_pend     <= 1'b0;
                r_blink    <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_pend     <= 1'b1;
                    r_pend_val <= cfg.cfg_half;
                end else if (w_term && r_pend) begin
                    r_pend <= 1'b0;
                    r_half <= r_pend_val;
                end

                if (i_sclr) begin
                    r_cnt   <= '0;
                    r_blink <= 1'b0;
                    r_tick  <= 1'b0;
                end else if (i_en) begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_blink <= ~r_blink;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end
        end

        assign w_pend[g]       = r_pend;
        assign w_blink[g]      = r_blink;
        assign w_blink_tick[g] = r_tick;
    end

    assign o_pixel_rate = r_pixel_rate;
    assign o_pixel_tick = r_pixel_tick;
    assign o_blink      = w_blink;
    assign o_blink_tick = w_blink_tick;
endmodule
